// File: rtl/hls_txn_pkg.sv
// hls_txn_pkg: shared types and helpers for the HLS transaction recorder.
//   txn_rec_t   - one latency record (start, done, latency), fields sized for
//                 the widest supported timestamp; narrower TS_W values are
//                 zero-extended into it.
//   trk_state_e - start-tracker FSM states.
//   sat_inc16   - 16-bit saturating increment used by the drop counter.
package hls_txn_pkg;

    localparam int TS_W_MAX = 32;

    typedef struct packed {
        logic [TS_W_MAX-1:0] start_ts;
        logic [TS_W_MAX-1:0] done_ts;
        logic [TS_W_MAX-1:0] latency;
    } txn_rec_t;

    typedef enum logic {
        TRK_IDLE       = 1'b0,
        TRK_WAIT_READY = 1'b1
    } trk_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/txn_sync_fifo.sv
// txn_sync_fifo: single-clock show-ahead FIFO.
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data    - push request and data
//   rd_en             - pop request (ignored while empty)
//   rd_data           - head entry, valid whenever empty=0; reads 0 when empty
//   full, empty       - occupancy flags
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module txn_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_rd, do_wr;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    // Force the head to zero when empty so idle outputs are clean.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/hls_txn_recorder.sv
// hls_txn_recorder: timestamps ap_start/ap_ready starts and ap_done/ap_continue
// completions of one HLS module, pairs them in order and streams one latency
// record per transaction.
//   clock, reset                         - clock, asynchronous active-high reset
//   ap_start, ap_ready, ap_done, ap_continue - observed handshake
//   finish                               - end of run, latched internally
//   rec_valid/rec_ready                  - record stream handshake (show-ahead)
//   rec_start_ts, rec_done_ts, rec_latency - record fields (TS_W bits)
//   txn_count, drop_count                - completed / dropped transactions
//   err_orphan, err_overflow             - sticky protocol error flags
//   drained                              - finished and fully idle (registered)
module hls_txn_recorder
    import hls_txn_pkg::*;
#(
    parameter int TS_W  = 32,
    parameter int OUTS  = 4,
    parameter int DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ap_start,
    input  logic            ap_ready,
    input  logic            ap_done,
    input  logic            ap_continue,
    input  logic            finish,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [TS_W-1:0] rec_start_ts,
    output logic [TS_W-1:0] rec_done_ts,
    output logic [TS_W-1:0] rec_latency,
    output logic [31:0]     txn_count,
    output logic [15:0]     drop_count,
    output logic            err_orphan,
    output logic            err_overflow,
    output logic            drained
);

    trk_state_e      state_q, state_d;
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] cap_ts_q, cap_ts_d;
    logic            finish_q;
    logic [31:0]     txn_count_q;
    logic [15:0]     drop_count_q;
    logic            err_orphan_q, err_overflow_q, drained_q;

    logic            start_cmp;
    logic [TS_W-1:0] start_ts;
    logic            done_evt, q_pop, q_push, bypass, rec_form;
    logic            orphan_set, overflow_set, rec_pop, rec_drop, drained_d;
    logic [TS_W-1:0] q_head, pair_start, pair_lat;
    logic            q_full, q_empty, rec_full, rec_empty;
    txn_rec_t        rec_wr, rec_head;

    // Start tracker: a start is complete when ap_start and ap_ready coincide;
    // the timestamp is that of the first cycle ap_start was seen.
    always_comb begin
        state_d   = state_q;
        cap_ts_d  = cap_ts_q;
        start_cmp = 1'b0;
        start_ts  = cap_ts_q;
        case (state_q)
            TRK_IDLE: begin
                if (ap_start && !finish_q) begin
                    if (ap_ready) begin
                        start_cmp = 1'b1;
                        start_ts  = ts_q;
                    end else begin
                        state_d  = TRK_WAIT_READY;
                        cap_ts_d = ts_q;
                    end
                end
            end
            TRK_WAIT_READY: begin
                if (ap_start && ap_ready) begin
                    start_cmp = 1'b1;
                    state_d   = TRK_IDLE;
                end else if (!ap_start) begin
                    // ap_start withdrawn before ready: discard the capture.
                    state_d = TRK_IDLE;
                end
            end
            default: state_d = TRK_IDLE;
        endcase
    end

    // Pairing: a done takes the oldest pending start; with nothing pending it
    // may pair directly with a start completing in the same cycle.
    assign done_evt     = ap_done && ap_continue;
    assign q_pop        = done_evt && !q_empty;
    assign bypass       = done_evt && q_empty && start_cmp;
    assign q_push       = start_cmp && !bypass;
    assign rec_form     = q_pop || bypass;
    assign orphan_set   = done_evt && q_empty && !start_cmp;
    assign overflow_set = q_push && q_full && !q_pop;
    assign pair_start   = q_pop ? q_head : start_ts;
    assign pair_lat     = ts_q - pair_start;

    assign rec_wr = '{start_ts: TS_W_MAX'(pair_start),
                      done_ts:  TS_W_MAX'(ts_q),
                      latency:  TS_W_MAX'(pair_lat)};

    assign rec_pop   = rec_valid && rec_ready;
    assign rec_drop  = rec_form && rec_full && !rec_pop;
    assign drained_d = finish_q && rec_empty && q_empty && (state_q == TRK_IDLE);

    txn_sync_fifo #(.DATA_W(TS_W), .DEPTH(OUTS)) u_outstanding (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (q_push),
        .wr_data(start_ts),
        .rd_en  (q_pop),
        .rd_data(q_head),
        .full   (q_full),
        .empty  (q_empty)
    );

    txn_sync_fifo #(.DATA_W($bits(txn_rec_t)), .DEPTH(DEPTH)) u_records (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (rec_form),
        .wr_data(rec_wr),
        .rd_en  (rec_pop),
        .rd_data(rec_head),
        .full   (rec_full),
        .empty  (rec_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= TRK_IDLE;
            ts_q           <= '0;
            cap_ts_q       <= '0;
            finish_q       <= 1'b0;
            txn_count_q    <= '0;
            drop_count_q   <= '0;
            err_orphan_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            drained_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_q + 1'b1;
            cap_ts_q  <= cap_ts_d;
            finish_q  <= finish_q | finish;
            drained_q <= drained_d;
            if (rec_form)     txn_count_q    <= txn_count_q + 32'd1;
            if (rec_drop)     drop_count_q   <= sat_inc16(drop_count_q);
            if (orphan_set)   err_orphan_q   <= 1'b1;
            if (overflow_set) err_overflow_q <= 1'b1;
        end
    end

    // Records carry TS_W_MAX-bit fields; only the low TS_W bits are meaningful.
    generate
        if (TS_W < TS_W_MAX) begin : g_trim
            logic unused_hi;
            assign unused_hi = ^{rec_head.start_ts[TS_W_MAX-1:TS_W],
                                 rec_head.done_ts[TS_W_MAX-1:TS_W],
                                 rec_head.latency[TS_W_MAX-1:TS_W]};
        end
    endgenerate

    assign rec_valid    = !rec_empty;
    assign rec_start_ts = rec_head.start_ts[TS_W-1:0];
    assign rec_done_ts  = rec_head.done_ts[TS_W-1:0];
    assign rec_latency  = rec_head.latency[TS_W-1:0];
    assign txn_count    = txn_count_q;
    assign drop_count   = drop_count_q;
    assign err_orphan   = err_orphan_q;
    assign err_overflow = err_overflow_q;
    assign drained      = drained_q;

endmodule
